// File: rtl/sweep_addr_gen.sv
// sweep_addr_gen: ROM address sweeper with wrap, ping-pong, one-shot burst and hold modes,
// plus a registered phase-offset address for the second ROM port.
module sweep_addr_gen #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] incr,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] limit,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_off,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
    localparam logic [1:0] M_WRAP = 2'b00;
    localparam logic [1:0] M_PING = 2'b01;
    localparam logic [1:0] M_ONE  = 2'b10;
    st_t st, st_n;
    logic [WIDTH:0]   sum;
    logic             over, below, dir_n, wrap_n;
    logic [WIDTH-1:0] cnt_n;
    // sum is one bit wider so the limit compare never sees a false wrap
    always_comb begin
        sum    = {1'b0, count} + {1'b0, incr};
        over   = sum > {1'b0, limit};
        below  = count < incr;
        cnt_n  = count;
        dir_n  = 1'b0;
        wrap_n = 1'b0;
        st_n   = IDLE;
        case (mode)
            M_WRAP: if (en) begin
                cnt_n  = sum[WIDTH-1:0];
                wrap_n = sum[WIDTH];
            end
            M_PING: begin
                dir_n = dir;
                if (en) begin
                    cnt_n = dir ? (below ? '0 : count - incr) : (over ? limit : sum[WIDTH-1:0]);
                    dir_n = dir ? !below : over;
                end
            end
            M_ONE: begin
                st_n = st;
                case (st)
                    IDLE, DONE: if (start) begin
                        st_n  = RUN;
                        cnt_n = '0;
                    end
                    RUN: if (en) begin
                        cnt_n = over ? limit : sum[WIDTH-1:0];
                        st_n  = over ? DONE : RUN;
                    end
                    default: st_n = IDLE;
                endcase
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            count     <= '0;
            count_off <= '0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            st        <= st_n;
            count     <= cnt_n;
            count_off <= cnt_n + offset;
            dir       <= dir_n;
            busy      <= st_n == RUN;
            done      <= st_n == DONE;
            wrap      <= wrap_n;
        end
    end
endmodule

// File: tb/tb_sweep_addr_gen.sv
// tb_sweep_addr_gen: directed vector table plus hand sequences for wrap, one-shot and offset corners.
module tb_sweep_addr_gen;
    logic       clk = 1'b0;
    logic       rst, en, start;
    logic [1:0] mode;
    logic [8:0] incr, offset, limit;
    logic [8:0] count, count_off;
    logic       dir, busy, done, wrap;
    int         checks = 0;
    int         failures = 0;

    sweep_addr_gen #(.WIDTH(9)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .incr(incr), .offset(offset),
        .limit(limit), .start(start), .count(count), .count_off(count_off),
        .dir(dir), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, start;
        logic [1:0] mode;
        logic [8:0] incr, offset, limit;
        logic [8:0] c, o;
        logic       d, b, dn, w;
    } vec_t;

    vec_t v[21];

    function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic [8:0] inc, logic [8:0] off,
                                logic [8:0] lim, logic s, logic [8:0] c, logic [8:0] o,
                                logic d, logic b, logic dn, logic w);
        vec_t x;
        x.rst = r; x.en = e; x.mode = m; x.incr = inc; x.offset = off; x.limit = lim; x.start = s;
        x.c = c; x.o = o; x.d = d; x.b = b; x.dn = dn; x.w = w;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic [8:0] c, logic [8:0] o, logic d, logic b, logic dn, logic w);
        chk({name, ".count"}, count, c);
        chk({name, ".count_off"}, count_off, o);
        chk({name, ".dir"}, {8'd0, dir}, {8'd0, d});
        chk({name, ".busy"}, {8'd0, busy}, {8'd0, b});
        chk({name, ".done"}, {8'd0, done}, {8'd0, dn});
        chk({name, ".wrap"}, {8'd0, wrap}, {8'd0, w});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; mode = 2'b00;
        incr = '0; offset = '0; limit = '0;
        // ping-pong triangle, then hold/wrap mode switches, en=0, limit=0 and incr=0 corners
        v[0]  = mk(1, 1, 2'd1, 4, 0, 10, 0,  0,  0, 0, 0, 0, 0);
        v[1]  = mk(0, 1, 2'd1, 4, 0, 10, 0,  4,  4, 0, 0, 0, 0);
        v[2]  = mk(0, 1, 2'd1, 4, 0, 10, 0,  8,  8, 0, 0, 0, 0);
        v[3]  = mk(0, 1, 2'd1, 4, 0, 10, 0, 10, 10, 1, 0, 0, 0);
        v[4]  = mk(0, 1, 2'd1, 4, 0, 10, 0,  6,  6, 1, 0, 0, 0);
        v[5]  = mk(0, 1, 2'd1, 4, 0, 10, 0,  2,  2, 1, 0, 0, 0);
        v[6]  = mk(0, 1, 2'd1, 4, 0, 10, 0,  0,  0, 0, 0, 0, 0);
        v[7]  = mk(0, 1, 2'd1, 4, 0, 10, 0,  4,  4, 0, 0, 0, 0);
        v[8]  = mk(0, 1, 2'd1, 4, 0, 10, 0,  8,  8, 0, 0, 0, 0);
        v[9]  = mk(0, 1, 2'd1, 4, 0, 10, 0, 10, 10, 1, 0, 0, 0);
        v[10] = mk(0, 1, 2'd1, 4, 0, 10, 0,  6,  6, 1, 0, 0, 0);
        v[11] = mk(0, 1, 2'd3, 4, 0, 10, 0,  6,  6, 0, 0, 0, 0);
        v[12] = mk(0, 1, 2'd3, 4, 0, 10, 0,  6,  6, 0, 0, 0, 0);
        v[13] = mk(0, 1, 2'd0, 4, 0, 10, 0, 10, 10, 0, 0, 0, 0);
        v[14] = mk(0, 1, 2'd0, 4, 0, 10, 0, 14, 14, 0, 0, 0, 0);
        v[15] = mk(0, 0, 2'd0, 4, 5, 10, 0, 14, 19, 0, 0, 0, 0);
        v[16] = mk(0, 0, 2'd1, 4, 5, 10, 0, 14, 19, 0, 0, 0, 0);
        v[17] = mk(0, 1, 2'd1, 4, 0,  0, 0,  0,  0, 1, 0, 0, 0);
        v[18] = mk(0, 1, 2'd1, 4, 0,  0, 0,  0,  0, 0, 0, 0, 0);
        v[19] = mk(0, 1, 2'd1, 4, 0,  0, 0,  0,  0, 1, 0, 0, 0);
        v[20] = mk(0, 1, 2'd0, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0);
        #2;
        for (int i = 0; i < 21; i++) begin
            rst = v[i].rst; en = v[i].en; mode = v[i].mode; incr = v[i].incr;
            offset = v[i].offset; limit = v[i].limit; start = v[i].start;
            step();
            chk_all($sformatf("vec%0d", i), v[i].c, v[i].o, v[i].d, v[i].b, v[i].dn, v[i].w);
        end

        // WRAP overflow: 170 steps of 3 reach 510, the next step wraps to 1 with a single pulse
        mode = 2'b00; incr = 9'd3; offset = '0; en = 1'b1;
        do_reset();
        chk_all("wrap_reset", 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 170; k++) begin
            step();
            chk("wrap_ramp.count", count, 9'(3 * k));
            chk("wrap_ramp.wrap", {8'd0, wrap}, 9'd0);
        end
        step();
        chk_all("wrap_over", 1, 1, 0, 0, 0, 1);
        step();
        chk_all("wrap_after", 4, 4, 0, 0, 0, 0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all("wrap_en0", 4, 4, 0, 0, 0, 0);
        end

        // offset: 20 + 500 wraps to 8; a zero offset shows next edge
        incr = 9'd1; offset = 9'd500; en = 1'b1;
        do_reset();
        for (int k = 1; k <= 20; k++) step();
        chk_all("off500", 20, 8, 0, 0, 0, 0);
        offset = '0;
        step();
        chk_all("off0", 21, 21, 0, 0, 0, 0);

        // ONESHOT burst, long DONE hold, restart, en=0 stall in RUN, reset mid-burst
        mode = 2'b10; limit = 9'd20; incr = 9'd7; en = 1'b1; start = 1'b1;
        do_reset();
        chk_all("os_idle", 0, 0, 0, 0, 0, 0);
        step();
        start = 1'b0;
        chk_all("os_start", 0, 0, 0, 1, 0, 0);
        step(); chk_all("os_7", 7, 7, 0, 1, 0, 0);
        step(); chk_all("os_14", 14, 14, 0, 1, 0, 0);
        step(); chk_all("os_done", 20, 20, 0, 0, 1, 0);
        for (int k = 0; k < 50; k++) begin
            step();
            chk("os_hold.count", count, 9'd20);
            chk("os_hold.done", {8'd0, done}, 9'd1);
        end
        start = 1'b1;
        step();
        chk_all("os_restart", 0, 0, 0, 1, 0, 0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all("os_en0", 0, 0, 0, 1, 0, 0);
        end
        en = 1'b1;
        step(); chk_all("os_ign_start", 7, 7, 0, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("os_14b", 14, 14, 0, 1, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("os_rst", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("os_idle_after_rst", 0, 0, 0, 0, 0, 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk_all("os_done2", 20, 20, 0, 0, 1, 0);
        mode = 2'b11;
        step();
        chk_all("os_leave", 20, 20, 0, 0, 0, 0);
        mode = 2'b10;
        step();
        chk_all("os_reenter_idle", 20, 20, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
